// File: rtl/trap_vector_ctrl_if.sv
// rtl/trap_vector_ctrl_if.sv - pipeline/fetch side signal bundle of the machine-mode trap sequencer
interface trap_vector_ctrl_if #(
  parameter int XLEN       = 64,
  parameter int NUM_CAUSES = 4
);
  localparam int CW = (NUM_CAUSES > 1) ? $clog2(NUM_CAUSES) : 1;

  logic [NUM_CAUSES-1:0] exc_req;
  logic [XLEN-1:0]       exc_pc;
  logic [XLEN-1:0]       exc_tval;
  logic                  mret_req;
  logic                  flush;
  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_pc;
  logic [XLEN-1:0]       mepc;
  logic [CW-1:0]         mcause;
  logic [XLEN-1:0]       mtval;
  logic                  in_trap;
  logic                  fatal;

  modport master (
    output exc_req, exc_pc, exc_tval, mret_req,
    input  flush, redirect_valid, redirect_pc, mepc, mcause, mtval, in_trap, fatal
  );

  modport slave (
    input  exc_req, exc_pc, exc_tval, mret_req,
    output flush, redirect_valid, redirect_pc, mepc, mcause, mtval, in_trap, fatal
  );
endinterface

// File: rtl/trap_vector_ctrl.sv
// rtl/trap_vector_ctrl.sv - machine-mode trap sequencer: priority capture, flush, vectored redirect, mret return
// Optional per-cause trap counters under macro TRAP_VECTOR_PERF_CNT_EN.
module trap_vector_ctrl #(
  parameter int XLEN         = 64,
  parameter int NUM_CAUSES   = 4,
  parameter int MTVEC_BASE   = 472,
  parameter int VEC_STRIDE   = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  trap_vector_ctrl_if.slave      bus
`ifdef TRAP_VECTOR_PERF_CNT_EN
  ,
  input  logic [((NUM_CAUSES > 1) ? $clog2(NUM_CAUSES) : 1)-1:0] cnt_sel,
  output logic [15:0]            cnt_val,
  input  logic                   cnt_clr
`endif
);
  localparam int CW = (NUM_CAUSES > 1) ? $clog2(NUM_CAUSES) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FLUSH    = 3'd1;
  localparam logic [2:0] S_REDIRECT = 3'd2;
  localparam logic [2:0] S_HANDLER  = 3'd3;
  localparam logic [2:0] S_RETURN   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [3:0]      fcnt_q, fcnt_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [CW-1:0]   mcause_q, mcause_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            fatal_q, fatal_d;

  logic            exc_any;
  logic            capture;
  logic [CW-1:0]   winner;
  logic [XLEN-1:0] vec_addr;

  assign exc_any = |bus.exc_req;
  assign capture = (state_q == S_IDLE) && exc_any;

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
      if (bus.exc_req[i]) winner = CW'(i);
    end
  end

  assign vec_addr = XLEN'(MTVEC_BASE) + XLEN'(VEC_STRIDE) * XLEN'(mcause_q);

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    mepc_d        = mepc_q;
    mtval_d       = mtval_q;
    mcause_d      = mcause_q;
    redirect_pc_d = redirect_pc_q;
    fatal_d       = fatal_q;
    case (state_q)
      S_IDLE: begin
        if (exc_any) begin
          mepc_d   = bus.exc_pc;
          mtval_d  = bus.exc_tval;
          mcause_d = winner;
          fcnt_d   = 4'(FLUSH_CYCLES - 1);
          state_d  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (fcnt_q == 4'd0) begin
          redirect_pc_d = vec_addr;
          state_d       = S_REDIRECT;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      S_REDIRECT: state_d = S_HANDLER;
      S_HANDLER: begin
        // A fault inside the handler cannot be nested; flag it and keep the first trap's context.
        if (exc_any) fatal_d = 1'b1;
        if (bus.mret_req) begin
          redirect_pc_d = mepc_q;
          state_d       = S_RETURN;
        end
      end
      S_RETURN: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      fcnt_q        <= '0;
      mepc_q        <= '0;
      mtval_q       <= '0;
      mcause_q      <= '0;
      redirect_pc_q <= '0;
      fatal_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      mepc_q        <= mepc_d;
      mtval_q       <= mtval_d;
      mcause_q      <= mcause_d;
      redirect_pc_q <= redirect_pc_d;
      fatal_q       <= fatal_d;
    end
  end

  assign bus.flush          = (state_q == S_FLUSH) || (state_q == S_RETURN);
  assign bus.redirect_valid = (state_q == S_REDIRECT) || (state_q == S_RETURN);
  assign bus.in_trap        = (state_q != S_IDLE);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.mepc           = mepc_q;
  assign bus.mcause         = mcause_q;
  assign bus.mtval          = mtval_q;
  assign bus.fatal          = fatal_q;

`ifdef TRAP_VECTOR_PERF_CNT_EN
  logic [15:0] perf_q [NUM_CAUSES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CAUSES; i++) perf_q[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < NUM_CAUSES; i++) perf_q[i] <= '0;
    end else if (capture && (perf_q[winner] != 16'hFFFF)) begin
      perf_q[winner] <= perf_q[winner] + 16'd1;
    end
  end

  assign cnt_val = perf_q[cnt_sel];
`endif
endmodule

// File: tb/tb_trap_vector_ctrl.sv
// tb/tb_trap_vector_ctrl.sv - directed plus randomized trap sequences checked against a behavioural model
module tb_trap_vector_ctrl;
  localparam int FC = 2;
  localparam longint BASE = 472;
  localparam longint STRIDE = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trap_vector_ctrl_if #(.XLEN(64), .NUM_CAUSES(4)) bus();

`ifdef TRAP_VECTOR_PERF_CNT_EN
  logic [1:0]  cnt_sel = 2'd0;
  logic [15:0] cnt_val;
  logic        cnt_clr = 1'b0;
`endif

  trap_vector_ctrl #(
    .XLEN(64), .NUM_CAUSES(4), .MTVEC_BASE(472), .VEC_STRIDE(8), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef TRAP_VECTOR_PERF_CNT_EN
    ,
    .cnt_sel(cnt_sel),
    .cnt_val(cnt_val),
    .cnt_clr(cnt_clr)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  bit fatal_exp = 1'b0;
  int exp_cnt [4] = '{0, 0, 0, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return 0;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // dbl: 0 = clean handler, 1 = separate fault pulse in handler, 2 = fault together with mret
  task automatic do_trap(input logic [3:0] req, input logic [63:0] pc, input logic [63:0] tv,
                         input int wait_n, input int dbl);
    int w;
    w = lowest(req);
    bus.exc_req = req; bus.exc_pc = pc; bus.exc_tval = tv;
    step();
    exp_cnt[w]++;
    chk("cap_in_trap", bus.in_trap, 1);
    chk("cap_flush", bus.flush, 1);
    chk("cap_rv", bus.redirect_valid, 0);
    chk("cap_mepc", bus.mepc, pc);
    chk("cap_mcause", bus.mcause, w);
    chk("cap_mtval", bus.mtval, tv);
    for (int i = 1; i < FC; i++) begin
      bus.exc_req = 4'($urandom_range(1, 15)); bus.exc_pc = rnd64(); bus.exc_tval = rnd64();
      step();
      chk("flush_hold", bus.flush, 1);
      chk("flush_rv", bus.redirect_valid, 0);
    end
    bus.exc_req = 4'($urandom_range(1, 15)); bus.exc_pc = rnd64();
    step();
    chk("vec_rv", bus.redirect_valid, 1);
    chk("vec_flush", bus.flush, 0);
    chk("vec_pc", bus.redirect_pc, BASE + STRIDE * w);
    chk("vec_mepc", bus.mepc, pc);
    chk("vec_mcause", bus.mcause, w);
    chk("vec_fatal", bus.fatal, fatal_exp);
    bus.exc_req = '0;
    step();
    chk("hdl_rv", bus.redirect_valid, 0);
    chk("hdl_in_trap", bus.in_trap, 1);
    for (int i = 0; i < wait_n; i++) begin
      step();
      chk("hdl_wait_rv", bus.redirect_valid, 0);
    end
    if (dbl == 1) begin
      bus.exc_req = 4'($urandom_range(1, 15)); bus.exc_pc = rnd64(); bus.exc_tval = rnd64();
      step();
      bus.exc_req = '0;
      fatal_exp = 1'b1;
      chk("dbl_fatal", bus.fatal, 1);
      chk("dbl_mepc", bus.mepc, pc);
      chk("dbl_mcause", bus.mcause, w);
      chk("dbl_mtval", bus.mtval, tv);
      chk("dbl_in_trap", bus.in_trap, 1);
    end
    bus.mret_req = 1'b1;
    if (dbl == 2) begin
      bus.exc_req = 4'($urandom_range(1, 15));
      fatal_exp = 1'b1;
    end
    step();
    bus.mret_req = 1'b0; bus.exc_req = '0;
    chk("ret_flush", bus.flush, 1);
    chk("ret_rv", bus.redirect_valid, 1);
    chk("ret_pc", bus.redirect_pc, pc);
    chk("ret_fatal", bus.fatal, fatal_exp);
    step();
    chk("post_in_trap", bus.in_trap, 0);
    chk("post_flush", bus.flush, 0);
    chk("post_rv", bus.redirect_valid, 0);
    chk("post_mepc", bus.mepc, pc);
  endtask

  initial begin
    logic [63:0] keep_pc;
    bus.exc_req = '0; bus.exc_pc = '0; bus.exc_tval = '0; bus.mret_req = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_rv", bus.redirect_valid, 0);
    end
    chk("rst_flush", bus.flush, 0);
    chk("rst_in_trap", bus.in_trap, 0);
    chk("rst_fatal", bus.fatal, 0);
    chk("rst_rpc", bus.redirect_pc, 0);
    chk("rst_mepc", bus.mepc, 0);
    chk("rst_mcause", bus.mcause, 0);
    chk("rst_mtval", bus.mtval, 0);

    do_trap(4'b0010, 64'h4, 64'h0023037F, 4, 0);
    do_trap(4'b0101, 64'h14, 64'h0, 2, 1);

    keep_pc = bus.mepc;
    bus.mret_req = 1'b1;
    step();
    bus.mret_req = 1'b0;
    chk("idle_mret_rv", bus.redirect_valid, 0);
    chk("idle_mret_in_trap", bus.in_trap, 0);
    chk("idle_mret_mepc", bus.mepc, keep_pc);

    for (int t = 0; t < 24; t++) begin
      do_trap(4'($urandom_range(1, 15)), rnd64(), rnd64(), $urandom_range(0, 5),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    end

    bus.exc_req = 4'b0001; bus.exc_pc = 64'h1234;
    step();
    bus.exc_req = '0;
    chk("pre_rst_flush", bus.flush, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_flush", bus.flush, 0);
    chk("arst_in_trap", bus.in_trap, 0);
    chk("arst_rv", bus.redirect_valid, 0);
    chk("arst_fatal", bus.fatal, 0);
    chk("arst_mepc", bus.mepc, 0);
    fatal_exp = 1'b0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("arst_after_rv", bus.redirect_valid, 0);

`ifdef TRAP_VECTOR_PERF_CNT_EN
    for (int t = 0; t < 3; t++) do_trap(4'b0100, rnd64(), rnd64(), 1, 0);
    do_trap(4'b1011, rnd64(), rnd64(), 0, 0);
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i);
      #1;
      chk("cnt_val", cnt_val, exp_cnt[i]);
    end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    cnt_sel = 2'd2;
    #1;
    chk("cnt_clr", cnt_val, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
